// File: rtl/control_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE sequencer for a 16-bit instruction set.
// It drives the register-file and ALU controls and sequences the program counter.
module control_sequencer #(
  parameter int         PC_W   = 8,
  parameter logic [3:0] ADD_OP = 4'h0
) (
  input  logic            clk,
  input  logic            rst,
  output logic [PC_W-1:0] imem_addr,
  input  logic [15:0]     imem_data,
  input  logic            run,
  input  logic            alu_zero,
  input  logic            alu_carry,
  output logic [3:0]      alu_opcode,
  output logic [3:0]      write_addr,
  output logic [3:0]      ra_addr,
  output logic [3:0]      rb_addr,
  output logic            write_en,
  output logic            write_alu,
  output logic            imm_flag,
  output logic [7:0]      top_data,
  output logic            halted,
  output logic            zero_flag,
  output logic            carry_flag
);

  typedef enum logic [1:0] {FETCH, DECODE, EXECUTE, HALTED} state_t;

  state_t          state, state_nxt;
  logic [PC_W-1:0] pc, pc_nxt, pc_inc, target;
  logic [15:0]     ir;
  logic            wr_pend;

  logic [3:0] d_aop, d_wa, d_ra, d_rb;
  logic       d_wr, d_walu, d_imm;
  logic [7:0] d_top;

  assign pc_inc    = pc + PC_W'(1);
  assign target    = PC_W'(ir[7:0]);
  assign imem_addr = pc;
  assign halted    = (state == HALTED);
  // Tied to the state register, so an async reset drops the strobe at once.
  assign write_en  = (state == EXECUTE) && wr_pend;

  // Decode straight from the ROM word while it is valid in DECODE.
  always_comb begin
    d_aop  = 4'h0;
    d_wa   = 4'h0;
    d_ra   = 4'h0;
    d_rb   = 4'h0;
    d_wr   = 1'b0;
    d_walu = 1'b0;
    d_imm  = 1'b0;
    d_top  = 8'h00;
    case (imem_data[15:12])
      4'hB: begin
        d_aop  = ADD_OP;
        d_wa   = imem_data[11:8];
        d_ra   = imem_data[11:8];
        d_top  = imem_data[7:0];
        d_imm  = 1'b1;
        d_walu = 1'b1;
        d_wr   = 1'b1;
      end
      4'hC: begin
        d_wa  = imem_data[11:8];
        d_top = imem_data[7:0];
        d_wr  = 1'b1;
      end
      4'hD, 4'hE, 4'hF: ;
      default: begin
        d_aop  = imem_data[15:12];
        d_wa   = imem_data[11:8];
        d_ra   = imem_data[7:4];
        d_rb   = imem_data[3:0];
        d_walu = 1'b1;
        d_wr   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir         <= 16'h0;
      alu_opcode <= 4'h0;
      write_addr <= 4'h0;
      ra_addr    <= 4'h0;
      rb_addr    <= 4'h0;
      wr_pend    <= 1'b0;
      write_alu  <= 1'b0;
      imm_flag   <= 1'b0;
      top_data   <= 8'h00;
    end else if (state == DECODE) begin
      ir         <= imem_data;
      alu_opcode <= d_aop;
      write_addr <= d_wa;
      ra_addr    <= d_ra;
      rb_addr    <= d_rb;
      wr_pend    <= d_wr;
      write_alu  <= d_walu;
      imm_flag   <= d_imm;
      top_data   <= d_top;
    end
  end

  // Only ALU-producing ops (0x0-0xB) refresh the flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero_flag  <= 1'b0;
      carry_flag <= 1'b0;
    end else if (state == EXECUTE && ir[15:12] <= 4'hB) begin
      zero_flag  <= alu_zero;
      carry_flag <= alu_carry;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FETCH;
      pc    <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    case (state)
      FETCH:  state_nxt = DECODE;
      DECODE: state_nxt = EXECUTE;
      EXECUTE: begin
        state_nxt = FETCH;
        pc_nxt    = pc_inc;
        case (ir[15:12])
          4'hD: if (zero_flag)  pc_nxt = target;
          4'hE: if (carry_flag) pc_nxt = target;
          4'hF: begin
            if (ir[11:8] == 4'h0) begin
              pc_nxt = target;
            end else if (ir[11:8] == 4'h1) begin
              state_nxt = HALTED;
              pc_nxt    = pc;
            end
          end
          default: ;
        endcase
      end
      HALTED: begin
        if (run) begin
          state_nxt = FETCH;
          pc_nxt    = pc_inc;
        end
      end
      default: state_nxt = FETCH;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: a table of single-instruction vectors
// plus hand-written halt/run and mid-execute reset sequences, with a write scoreboard.
module tb_control_sequencer;

  logic        clk, rst, run, alu_zero, alu_carry;
  logic [7:0]  imem_addr;
  logic [15:0] imem_data;
  logic [3:0]  alu_opcode, write_addr, ra_addr, rb_addr;
  logic        write_en, write_alu, imm_flag, halted, zero_flag, carry_flag;
  logic [7:0]  top_data;

  control_sequencer #(.PC_W(8), .ADD_OP(4'h0)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
    .run(run), .alu_zero(alu_zero), .alu_carry(alu_carry),
    .alu_opcode(alu_opcode), .write_addr(write_addr), .ra_addr(ra_addr),
    .rb_addr(rb_addr), .write_en(write_en), .write_alu(write_alu),
    .imm_flag(imm_flag), .top_data(top_data), .halted(halted),
    .zero_flag(zero_flag), .carry_flag(carry_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] rom [256];
  always @(posedge clk) imem_data <= rom[imem_addr];

  typedef struct {
    logic [15:0] instr;
    logic        z_in, c_in, wr;
    logic [3:0]  waddr, ra, rb, aop;
    logic        walu, imm;
    logic [7:0]  top, pc_next;
    logic        z_exp, c_exp;
  } vec_t;

  typedef struct {
    logic [3:0] waddr, ra, rb, aop;
    logic       walu, imm;
    logic [7:0] top;
  } wr_t;

  vec_t vecs [12];
  wr_t  sb [$];
  int   n_chk = 0, n_fail = 0;
  logic [7:0] pc_exp;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (!rst && write_en) begin
      if (sb.size() == 0) begin
        check("unexpected_write", 32'(write_en), 32'd0);
      end else begin
        wr_t e;
        e = sb.pop_front();
        check("sb_write_addr", 32'(write_addr), 32'(e.waddr));
        check("sb_ra_addr",    32'(ra_addr),    32'(e.ra));
        check("sb_rb_addr",    32'(rb_addr),    32'(e.rb));
        check("sb_alu_opcode", 32'(alu_opcode), 32'(e.aop));
        check("sb_write_alu",  32'(write_alu),  32'(e.walu));
        check("sb_imm_flag",   32'(imm_flag),   32'(e.imm));
        check("sb_top_data",   32'(top_data),   32'(e.top));
      end
    end
  end

  task automatic apply(input vec_t v);
    check("fetch_addr", 32'(imem_addr), 32'(pc_exp));
    rom[pc_exp] = v.instr;
    if (v.wr) sb.push_back('{v.waddr, v.ra, v.rb, v.aop, v.walu, v.imm, v.top});
    step();
    check("decode_no_write", 32'(write_en), 32'd0);
    step();
    alu_zero  = v.z_in;
    alu_carry = v.c_in;
    check("exec_write_en", 32'(write_en), 32'(v.wr));
    step();
    check("next_pc",    32'(imem_addr),  32'(v.pc_next));
    check("zero_flag",  32'(zero_flag),  32'(v.z_exp));
    check("carry_flag", 32'(carry_flag), 32'(v.c_exp));
    check("not_halted", 32'(halted),     32'd0);
    pc_exp = v.pc_next;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //           instr    zi  ci  wr waddr ra    rb    aop   walu imm top    pc     z   c
    vecs[0]  = '{16'hC35A, 1, 0, 1, 4'h3, 4'h0, 4'h0, 4'h0, 0, 0, 8'h5A, 8'h01, 0, 0};
    vecs[1]  = '{16'h0123, 1, 0, 1, 4'h1, 4'h2, 4'h3, 4'h0, 1, 0, 8'h00, 8'h02, 1, 0};
    vecs[2]  = '{16'hD040, 0, 1, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 8'h00, 8'h40, 1, 0};
    vecs[3]  = '{16'h5456, 0, 1, 1, 4'h4, 4'h5, 4'h6, 4'h5, 1, 0, 8'h00, 8'h41, 0, 1};
    vecs[4]  = '{16'hD020, 1, 1, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 8'h00, 8'h42, 0, 1};
    vecs[5]  = '{16'hE080, 0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 8'h00, 8'h80, 0, 1};
    vecs[6]  = '{16'hB733, 0, 0, 1, 4'h7, 4'h7, 4'h0, 4'h0, 1, 1, 8'h33, 8'h81, 0, 0};
    vecs[7]  = '{16'hE010, 1, 1, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 8'h00, 8'h82, 0, 0};
    vecs[8]  = '{16'hA0F1, 1, 1, 1, 4'h0, 4'hF, 4'h1, 4'hA, 1, 0, 8'h00, 8'h83, 1, 1};
    vecs[9]  = '{16'hF0FF, 0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 8'h00, 8'hFF, 1, 1};
    vecs[10] = '{16'hF2AB, 0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 8'h00, 8'h00, 1, 1};
    vecs[11] = '{16'hF010, 0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 8'h00, 8'h10, 1, 1};

    for (int i = 0; i < 256; i++) rom[i] = 16'h0;
    rst = 1'b1; run = 1'b0; alu_zero = 1'b0; alu_carry = 1'b0;
    #1;
    check("rst_imem_addr",  32'(imem_addr),  32'h0);
    check("rst_write_en",   32'(write_en),   32'h0);
    check("rst_halted",     32'(halted),     32'h0);
    check("rst_write_alu",  32'(write_alu),  32'h0);
    check("rst_alu_opcode", 32'(alu_opcode), 32'h0);
    check("rst_top_data",   32'(top_data),   32'h0);
    check("rst_flags",      32'({zero_flag, carry_flag}), 32'h0);
    step();
    step();
    rst = 1'b0;
    pc_exp = 8'h00;

    for (int i = 0; i < 12; i++) apply(vecs[i]);

    // HALT at 0x10, then resume with a run pulse.
    rom[8'h10] = 16'hF100;
    step();
    step();
    check("halt_exec_no_write", 32'(write_en), 32'd0);
    step();
    for (int i = 0; i < 3; i++) begin
      check("halted_hold",   32'(halted),    32'd1);
      check("halted_no_wr",  32'(write_en),  32'd0);
      check("halted_pc",     32'(imem_addr), 32'h10);
      step();
    end
    run = 1'b1;
    step();
    run = 1'b0;
    check("resume_halted", 32'(halted),    32'd0);
    check("resume_pc",     32'(imem_addr), 32'h11);

    // Reset in the middle of an ADDI execute cycle.
    rom[8'h11] = 16'hB7FF;
    step();
    step();
    check("addi_write_en", 32'(write_en), 32'd1);
    check("addi_imm_flag", 32'(imm_flag), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check("abort_write_en", 32'(write_en),  32'd0);
    check("abort_pc",       32'(imem_addr), 32'h0);
    check("abort_flags",    32'({zero_flag, carry_flag}), 32'h0);
    check("abort_top_data", 32'(top_data),  32'h0);
    step();
    rst = 1'b0;
    pc_exp = 8'h00;
    apply(vecs[0]);

    step();
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
